// File: rtl/obstacle_column_gen.sv
// obstacle_column_gen
//
// Purpose:
//   Produces a stream of 30-row column bitmaps for a side-scrolling obstacle
//   field. Each obstacle is PIPE_W solid columns with a GAP_H-row opening,
//   separated by SPACE_W empty columns. A new column is generated for every
//   accepted frame tick and offered on a valid/ready handshake.
//
// Configuration:
//   OBSTACLE_LFSR_EN - when defined, the gap position comes from an 8-bit
//                      Fibonacci LFSR loaded from 'seed' during reset. When
//                      undefined (default), the gap position steps by 5 rows
//                      per obstacle and 'seed' is unused.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   resetn     in   synchronous active-low reset
//   step       in   one-cycle frame tick, requests the next column
//   run        in   generator enable
//   seed[7:0]  in   LFSR load value, sampled only during reset
//   col_ready  in   consumer accepts col_data this cycle
//   col_valid  out  col_data holds an unaccepted column
//   col_data   out  column bitmap, bit r = 1 means obstacle in row r
//   gap_top    out  top row of the current/last pipe gap
//   overrun    out  sticky: a step arrived while a column was still pending

module obstacle_column_gen #(
    parameter int PIPE_W  = 4,
    parameter int SPACE_W = 10,
    parameter int GAP_H   = 8
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        step,
    input  logic        run,
    input  logic [7:0]  seed,
    input  logic        col_ready,
    output logic        col_valid,
    output logic [29:0] col_data,
    output logic [4:0]  gap_top,
    output logic        overrun
);

    localparam int MAX_W   = (PIPE_W > SPACE_W) ? PIPE_W : SPACE_W;
    localparam int CNT_W   = $clog2(MAX_W + 1);
    localparam int GAP_LIM = 29 - GAP_H;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PIPE  = CNT_W'(PIPE_W);
    localparam logic [CNT_W-1:0] CNT_SPACE = CNT_W'(SPACE_W);
    localparam logic [5:0]       LIM6      = 6'(GAP_LIM);

    // GAP_H ones in the low rows; shifted up by gap_top to carve the opening.
    localparam logic [29:0] GAP_MASK = 30'((31'd1 << GAP_H) - 31'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPACE = 2'd1,
        PIPE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
    logic               col_valid_q, col_valid_d;
    logic [29:0]        col_data_q, col_data_d;
    logic [4:0]         gap_top_q, gap_top_d;
    logic               overrun_q, overrun_d;

    logic               accept;
    logic               emit_pipe;
    logic               enter_pipe;
    logic [4:0]         gap_src;

`ifdef OBSTACLE_LFSR_EN
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         lfsr_adv;
`else
    logic               unused_seed;
    assign unused_seed = ^seed;
`endif

    // Maps a raw 5-bit value into the legal gap range 1..GAP_LIM. Zero maps
    // to 1 and values above the limit are folded down by GAP_LIM. The fold is
    // repeated so that large GAP_H values (small limits) still land in range;
    // for limits of 16 or more a single fold is all that ever happens.
    function automatic logic [4:0] map_gap(input logic [4:0] v);
        logic [5:0] g;
        g = {1'b0, v};
        if (g == 6'd0) begin
            g = 6'd1;
        end
        for (int i = 0; i < 31; i++) begin
            if (g > LIM6) begin
                g = g - LIM6;
            end
        end
        return g[4:0];
    endfunction

    // State register: every flop in the block, with synchronous reset that
    // overrides any handshake in progress.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
            gap_top_q   <= 5'd1;
            overrun_q   <= 1'b0;
`ifdef OBSTACLE_LFSR_EN
            // An all-zero LFSR would lock up, so a zero seed loads 1 instead.
            lfsr_q      <= (seed == 8'h00) ? 8'h01 : seed;
`endif
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            col_valid_q <= col_valid_d;
            col_data_q  <= col_data_d;
            gap_top_q   <= gap_top_d;
            overrun_q   <= overrun_d;
`ifdef OBSTACLE_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // Source value for the next gap position, computed from current state so
    // it is only committed when a pipe actually starts.
`ifdef OBSTACLE_LFSR_EN
    always_comb begin
        lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        gap_src  = lfsr_adv[4:0];
    end
`else
    always_comb begin
        gap_src = gap_top_q + 5'd5;
    end
`endif

    // Next-state logic. A step is taken only when the output slot is free or
    // being emptied this cycle; a step that finds the slot full is dropped
    // and flagged without touching the sequence position.
    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        col_valid_d = col_valid_q;
        gap_top_d   = gap_top_q;
        overrun_d   = overrun_q;
        emit_pipe   = 1'b0;
        enter_pipe  = 1'b0;
`ifdef OBSTACLE_LFSR_EN
        lfsr_d      = lfsr_q;
`endif

        accept = run && step && (!col_valid_q || col_ready);

        if (run && step && col_valid_q && !col_ready) begin
            overrun_d = 1'b1;
        end

        if (accept) begin
            col_valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    state_d   = SPACE;
                    col_cnt_d = CNT_ONE;
                end
                SPACE: begin
                    if (col_cnt_q == CNT_SPACE) begin
                        state_d    = PIPE;
                        col_cnt_d  = CNT_ONE;
                        enter_pipe = 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_ONE;
                    end
                end
                PIPE: begin
                    if (col_cnt_q == CNT_PIPE) begin
                        state_d   = SPACE;
                        col_cnt_d = CNT_ONE;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_ONE;
                        emit_pipe = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    col_cnt_d = '0;
                end
            endcase
        end else if (col_valid_q && col_ready) begin
            col_valid_d = 1'b0;
        end

        if (enter_pipe) begin
            emit_pipe = 1'b1;
            gap_top_d = map_gap(gap_src);
`ifdef OBSTACLE_LFSR_EN
            lfsr_d    = lfsr_adv;
`endif
        end

        // With the generator disabled, fall back to IDLE as soon as there is
        // no column left to hand over.
        if (!run && !col_valid_d) begin
            state_d   = IDLE;
            col_cnt_d = '0;
        end
    end

    // Output logic: builds the column for an accepted step and holds the
    // presented column steady otherwise.
    always_comb begin
        col_data_d = col_data_q;
        if (accept) begin
            if (emit_pipe) begin
                col_data_d = ~(GAP_MASK << gap_top_d);
            end else begin
                col_data_d = '0;
            end
        end

        col_valid = col_valid_q;
        col_data  = col_data_q;
        gap_top   = gap_top_q;
        overrun   = overrun_q;
    end

endmodule
